decode_stage: RTL and testbench



---
 rtl/decode_stage_if.sv | 46 ++++
 rtl/decode_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side, regfile/compare-side and execute-side signals of the decode stage.
// Latency: none (wiring only); the slave modport is the decode stage's view.
// Backpressure: in_valid/in_ready towards fetch, out_valid/out_ready towards execute.
interface decode_stage_if #(
  parameter int DATA_W = 32
);
  // fetch side
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] instr_addr;
  // register-read / compare side
  logic [4:0]        dec_src1;
  logic [4:0]        dec_src2;
  logic              a_eq;
  logic              a_lt;
  logic              a_gt;
  // execute side
  logic              out_valid;
  logic              out_ready;
  logic              jump;
  logic              pc_load_imm;
  logic              wr;
  logic              memrd;
  logic              memwr;
  logic              immediate;
  logic              jal;
  logic [4:0]        alu_op;
  logic [4:0]        src1;
  logic [4:0]        src2;
  logic [4:0]        dest;
  logic [DATA_W-1:0] imm_val;
  logic              illegal;

  modport slave (
    input  in_valid, instr, instr_addr, a_eq, a_lt, a_gt, out_ready,
    output in_ready, dec_src1, dec_src2, out_valid, jump, pc_load_imm, wr,
           memrd, memwr, immediate, jal, alu_op, src1, src2, dest, imm_val, illegal
  );

  modport master (
    output in_valid, instr, instr_addr, a_eq, a_lt, a_gt, out_ready,
    input  in_ready, dec_src1, dec_src2, out_valid, jump, pc_load_imm, wr,
           memrd, memwr, immediate, jal, alu_op, src1, src2, dest, imm_val, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered decoder of the 6-bit-opcode ISA into execute control bundles; optional ILLEGAL_OP_TRAP_EN.
// Latency: 1 cycle from acceptance to out_valid; one-entry output register, branches resolve at decode.
// Backpressure: in_ready low while the bundle is held, on a load-use hazard, or after an illegal-op trap.
module decode_stage #(
  parameter int DATA_W       = 32,
  parameter int LINK_REG     = 31,
  parameter int FLUSH_SLOTS  = 1,
  parameter int SIGN_EXT_IMM = 0
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave io
);

  typedef struct packed {
    logic              jump;
    logic              pc_load_imm;
    logic              wr;
    logic              memrd;
    logic              memwr;
    logic              immediate;
    logic              jal;
    logic [4:0]        alu_op;
    logic [4:0]        src1;
    logic [4:0]        src2;
    logic [4:0]        dest;
    logic [DATA_W-1:0] imm_val;
  } bundle_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [4:0] LINK       = 5'(LINK_REG);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS);

  logic [5:0]        op;
  logic [4:0]        rd, rs, rt;
  logic [DATA_W-1:0] imm_alu, off15, br_target, mem_off;
  logic              mem_sub;
  bundle_t           dec;
  logic              cond;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              out_valid_q;
  bundle_t           bundle_q;
  logic              illegal_q;
  logic              free, hazard, in_ready, load;

  assign op = io.instr[31:26];
  assign rd = io.instr[25:21];
  assign rs = io.instr[20:16];
  assign rt = io.instr[15:11];

  assign imm_alu   = (SIGN_EXT_IMM != 0) ? {{(DATA_W-16){io.instr[15]}}, io.instr[15:0]}
                                         : DATA_W'(io.instr[15:0]);
  // Bit 15 is a sign-magnitude direction flag for memory and branch offsets.
  assign off15     = DATA_W'(io.instr[14:0]);
  assign mem_off   = off15;
  assign mem_sub   = io.instr[15];
  assign br_target = io.instr[15] ? (io.instr_addr - off15) : (io.instr_addr + off15);

  // Decode the offered instruction into a candidate bundle; unused fields stay 0.
  always_comb begin
    dec  = '0;
    cond = 1'b0;
    case (op)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11: begin
        dec.wr     = 1'b1;
        dec.alu_op = op[4:0] - 5'd1;
        dec.dest   = rd;
        dec.src1   = rs;
        dec.src2   = rt;
      end
      6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26: begin
        dec.wr        = 1'b1;
        dec.immediate = 1'b1;
        dec.alu_op    = op[4:0] - 5'd17;
        dec.dest      = rd;
        dec.src1      = rs;
        dec.src2      = rs;
        dec.imm_val   = imm_alu;
      end
      6'd12: begin
        dec.jump        = 1'b1;
        dec.pc_load_imm = 1'b1;
        dec.wr          = 1'b1;
        dec.jal         = 1'b1;
        dec.dest        = LINK;
        dec.imm_val     = DATA_W'(io.instr[25:0]);
      end
      6'd13: begin
        dec.jump = 1'b1;
        dec.src1 = LINK;
        dec.src2 = LINK;
      end
      6'd14: begin
        dec.jump        = 1'b1;
        dec.pc_load_imm = 1'b1;
        dec.imm_val     = DATA_W'(io.instr[25:0]);
      end
      6'd15: begin
        dec.wr      = 1'b1;
        dec.dest    = rd;
        dec.imm_val = DATA_W'({io.instr[15:0], 16'h0000});
      end
      6'd16: begin
        dec.wr   = 1'b1;
        dec.dest = rd;
        dec.src1 = rs;
      end
      6'd29: begin
        dec.wr      = 1'b1;
        dec.dest    = rd;
        dec.imm_val = DATA_W'(io.instr[20:0]);
      end
      6'd27: begin
        dec.wr      = 1'b1;
        dec.memrd   = 1'b1;
        dec.dest    = rd;
        dec.src1    = rs;
        dec.imm_val = mem_off;
        dec.alu_op  = mem_sub ? 5'd1 : 5'd0;
      end
      6'd28: begin
        dec.memwr   = 1'b1;
        dec.src1    = rs;
        dec.src2    = rd;
        dec.imm_val = mem_off;
        dec.alu_op  = mem_sub ? 5'd1 : 5'd0;
      end
      6'd36: begin
        dec.wr   = 1'b1;
        dec.jal  = 1'b1;
        dec.dest = rd;
      end
      6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35: begin
        case (op)
          6'd30:   cond = io.a_eq;
          6'd31:   cond = !io.a_eq;
          6'd32:   cond = io.a_gt;
          6'd33:   cond = io.a_lt;
          6'd34:   cond = io.a_gt | io.a_eq;
          default: cond = io.a_lt | io.a_eq;
        endcase
        dec.src1        = rd;
        dec.src2        = rs;
        dec.alu_op      = 5'd1;
        dec.imm_val     = br_target;
        dec.jump        = cond;
        dec.pc_load_imm = cond;
      end
      default: dec = '0;
    endcase
  end

  // Unused source fields decode to 0 and a hazard needs dest!=0, so only real reads can match.
  assign free   = !out_valid_q || io.out_ready;
  assign hazard = out_valid_q && bundle_q.memrd && (bundle_q.dest != 5'd0) && io.in_valid &&
                  ((dec.src1 == bundle_q.dest) || (dec.src2 == bundle_q.dest));

  // RUN/FLUSH next-state: after a taken jump, drop FLUSH_SLOTS wrong-path instructions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    load     = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = free && !hazard && !illegal_q;
        load     = io.in_valid && in_ready;
        if (load && dec.jump) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      FLUSH: begin
        in_ready = free;
        if (io.in_valid && in_ready) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output skid register: load on acceptance, clear valid once execute takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      bundle_q    <= dec;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  // Sticky trap: an accepted opcode >= 37 issues as a nop and then blocks fetch until reset.
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else if (load && (op >= 6'd37)) illegal_q <= 1'b1;
  end
`else
  // Without the trap, unknown opcodes simply flow through as nops.
  assign illegal_q = 1'b0;
`endif

  assign io.in_ready    = in_ready;
  assign io.dec_src1    = dec.src1;
  assign io.dec_src2    = dec.src2;
  assign io.out_valid   = out_valid_q;
  assign io.jump        = bundle_q.jump;
  assign io.pc_load_imm = bundle_q.pc_load_imm;
  assign io.wr          = bundle_q.wr;
  assign io.memrd       = bundle_q.memrd;
  assign io.memwr       = bundle_q.memwr;
  assign io.immediate   = bundle_q.immediate;
  assign io.jal         = bundle_q.jal;
  assign io.alu_op      = bundle_q.alu_op;
  assign io.src1        = bundle_q.src1;
  assign io.src2        = bundle_q.src2;
  assign io.dest        = bundle_q.dest;
  assign io.imm_val     = bundle_q.imm_val;
  assign io.illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven vectors with a scoreboard queue plus hand sequences for stalls, flushes and reset.
// Latency: expects each accepted bundle on out_valid one cycle after acceptance.
// Backpressure: drives out_ready low to check bundle hold and fetch stall.
module tb_decode_stage;

  typedef struct packed {
    logic        jump, pcl, wr, memrd, memwr, immediate, jal;
    logic [4:0]  alu, s1, s2, dst;
    logic [31:0] imm;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [2:0]  flags; // {a_eq, a_lt, a_gt}
    bit          exp_out;
    out_t        exp;
  } vec_t;

  localparam logic [6:0] C_JMP = 7'b1000000;
  localparam logic [6:0] C_PCL = 7'b0100000;
  localparam logic [6:0] C_WR  = 7'b0010000;
  localparam logic [6:0] C_MRD = 7'b0001000;
  localparam logic [6:0] C_MWR = 7'b0000100;
  localparam logic [6:0] C_IMM = 7'b0000010;
  localparam logic [6:0] C_JAL = 7'b0000001;
  localparam int NV = 28;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(32)) io();

  decode_stage #(.DATA_W(32), .LINK_REG(31), .FLUSH_SLOTS(1), .SIGN_EXT_IMM(0)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  vec_t tbl[NV];
  out_t mon_act, mon_exp;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                                      input logic [15:0] lo);
    return {op, a, b, lo};
  endfunction

  function automatic out_t o(input logic [6:0] ctl, input logic [4:0] alu, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [4:0] d, input logic [31:0] iv);
    out_t r;
    {r.jump, r.pcl, r.wr, r.memrd, r.memwr, r.immediate, r.jal} = ctl;
    r.alu = alu; r.s1 = s1; r.s2 = s2; r.dst = d; r.imm = iv;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] addr, input logic [2:0] fl,
                               input bit eo, input out_t e);
    vec_t v;
    v.instr = instr; v.addr = addr; v.flags = fl; v.exp_out = eo; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Offer one instruction; push its expected bundle when the stage accepts it.
  task automatic offer(input vec_t v);
    bit ok = 1'b0;
    io.instr = v.instr; io.instr_addr = v.addr;
    {io.a_eq, io.a_lt, io.a_gt} = v.flags;
    io.in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (io.in_ready) begin
        ok = 1'b1;
        if (v.exp_out) exp_q.push_back(v.exp);
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL offer_timeout instr=%h never accepted", v.instr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    io.in_valid = 1'b0; io.instr = '0; io.instr_addr = '0;
    io.a_eq = 1'b0; io.a_lt = 1'b0; io.a_gt = 1'b0;
    io.out_ready = 1'b1;
    reset = 1'b1;

    tbl[0]  = mkv(32'h04611000, 0, 3'b000, 1, o(C_WR, 0, 1, 2, 3, 0));
    tbl[1]  = mkv(enc(18, 6, 7, 16'hFFF0), 0, 3'b000, 1, o(C_WR | C_IMM, 1, 7, 7, 6, 32'h0000FFF0));
    tbl[2]  = mkv(enc(11, 1, 2, 16'h1800), 0, 3'b000, 1, o(C_WR, 10, 2, 3, 1, 0));
    tbl[3]  = mkv(32'h3C40ABCD, 0, 3'b000, 1, o(C_WR, 0, 0, 0, 2, 32'hABCD0000));
    tbl[4]  = mkv({6'd29, 5'd9, 21'h1ABCD}, 0, 3'b000, 1, o(C_WR, 0, 0, 0, 9, 32'h0001ABCD));
    tbl[5]  = mkv(enc(28, 5, 6, 16'h8010), 0, 3'b000, 1, o(C_MWR, 1, 6, 5, 0, 32'h10));
    tbl[6]  = mkv(enc(16, 4, 8, 16'h0000), 0, 3'b000, 1, o(C_WR, 0, 8, 0, 4, 0));
    tbl[7]  = mkv(enc(36, 7, 0, 16'h0000), 0, 3'b000, 1, o(C_WR | C_JAL, 0, 0, 0, 7, 0));
    tbl[8]  = mkv(enc(24, 10, 11, 16'h8001), 0, 3'b000, 1, o(C_WR | C_IMM, 7, 11, 11, 10, 32'h8001));
    tbl[9]  = mkv(32'h78228004, 32'h100, 3'b000, 1, o(0, 1, 1, 2, 0, 32'hFC));
    tbl[10] = mkv(enc(35, 3, 4, 16'h0020), 32'h1000, 3'b001, 1, o(0, 1, 3, 4, 0, 32'h1020));
    tbl[11] = mkv(enc(34, 3, 4, 16'h0010), 32'h2000, 3'b001, 1, o(C_JMP | C_PCL, 1, 3, 4, 0, 32'h2010));
    tbl[12] = mkv(enc(1, 9, 9, 16'h4800), 0, 3'b000, 0, '0);
    tbl[13] = mkv({6'd12, 26'h0123456}, 0, 3'b000, 1, o(C_JMP | C_PCL | C_WR | C_JAL, 0, 0, 0, 31, 32'h00123456));
    tbl[14] = mkv(enc(5, 1, 1, 16'h0800), 0, 3'b000, 0, '0);
    tbl[15] = mkv({6'd13, 26'h0}, 0, 3'b000, 1, o(C_JMP, 0, 31, 31, 0, 0));
    tbl[16] = mkv(enc(2, 3, 3, 16'h1800), 0, 3'b000, 0, '0);
    tbl[17] = mkv(enc(27, 4, 1, 16'h8003), 0, 3'b000, 1, o(C_WR | C_MRD, 1, 1, 0, 4, 32'h3));
    tbl[18] = mkv(enc(3, 7, 1, 16'h1000), 0, 3'b000, 1, o(C_WR, 2, 1, 2, 7, 0));
    tbl[19] = mkv(enc(31, 2, 3, 16'h0004), 32'h40, 3'b000, 1, o(C_JMP | C_PCL, 1, 2, 3, 0, 32'h44));
    tbl[20] = mkv(enc(1, 2, 2, 16'h1000), 0, 3'b000, 0, '0);
    tbl[21] = mkv({6'd14, 26'h3FFFFFF}, 0, 3'b000, 1, o(C_JMP | C_PCL, 0, 0, 0, 0, 32'h03FFFFFF));
    tbl[22] = mkv(enc(4, 6, 6, 16'h3000), 0, 3'b000, 0, '0);
    tbl[23] = mkv(enc(33, 1, 2, 16'h8001), 0, 3'b100, 1, o(0, 1, 1, 2, 0, 32'hFFFFFFFF));
    tbl[24] = mkv(enc(21, 3, 4, 16'h00FF), 0, 3'b000, 1, o(C_WR | C_IMM, 4, 4, 4, 3, 32'hFF));
    tbl[25] = mkv(32'h78228004, 32'h100, 3'b100, 1, o(C_JMP | C_PCL, 1, 1, 2, 0, 32'hFC));
    tbl[26] = mkv(enc(1, 8, 8, 16'h4000), 0, 3'b000, 0, '0);
    tbl[27] = mkv(enc(4, 2, 3, 16'h2000), 0, 3'b000, 1, o(C_WR, 3, 3, 4, 2, 0));

    // Scoreboard monitor: every transfer to execute must match the oldest expected bundle.
    fork
      begin
        forever begin
          @(negedge clk);
          if (!reset && io.out_valid && io.out_ready) begin
            mon_act = {io.jump, io.pc_load_imm, io.wr, io.memrd, io.memwr, io.immediate, io.jal,
                       io.alu_op, io.src1, io.src2, io.dest, io.imm_val};
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_bundle actual=%h expected=none", mon_act);
            end else begin
              mon_exp = exp_q.pop_front();
              if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL bundle actual=%h expected=%h", mon_act, mon_exp);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", io.out_valid, 0);
    chk("reset_illegal", io.illegal, 0);
    chk("reset_in_ready", io.in_ready, 1);
    chk("reset_bundle", {io.jump, io.pc_load_imm, io.wr, io.memrd, io.memwr, io.immediate, io.jal,
                         io.alu_op, io.src1, io.src2, io.dest, io.imm_val}, 0);
    io.instr = 32'h78228004;
    #1;
    chk("dec_src1", io.dec_src1, 1);
    chk("dec_src2", io.dec_src2, 2);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      offer(tbl[i]);
      chk(tbl[i].exp_out ? "issue_latency" : "flush_drop", io.out_valid, tbl[i].exp_out);
    end

    // Held bundle under backpressure.
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    offer(mkv(32'h3C40ABCD, 0, 3'b000, 1, o(C_WR, 0, 0, 0, 2, 32'hABCD0000)));
    io.instr = 32'h04611000; io.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", io.out_valid, 1);
      chk("hold_imm", io.imm_val, 32'hABCD0000);
      chk("hold_in_ready", io.in_ready, 0);
    end
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    offer(mkv(32'h04611000, 0, 3'b000, 1, o(C_WR, 0, 1, 2, 3, 0)));

    // Load-use hazard: one stall, one bubble, consumer issues on the third cycle.
    offer(mkv(32'h6C810008, 0, 3'b000, 1, o(C_WR | C_MRD, 0, 1, 0, 4, 32'h8)));
    io.instr = 32'h04A42000; io.in_valid = 1'b1;
    @(negedge clk);
    chk("hazard_in_ready", io.in_ready, 0);
    chk("hazard_load_valid", io.out_valid, 1);
    @(negedge clk);
    chk("hazard_bubble", io.out_valid, 0);
    chk("hazard_release", io.in_ready, 1);
    if (io.in_ready) exp_q.push_back(o(C_WR, 0, 4, 4, 5, 0));
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    chk("hazard_issue", io.out_valid, 1);

`ifdef ILLEGAL_OP_TRAP_EN
    offer(mkv(32'hFC000000, 0, 3'b000, 1, '0));
    chk("illegal_set", io.illegal, 1);
    io.instr = 32'h04611000; io.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("illegal_block", io.in_ready, 0);
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("illegal_cleared", io.illegal, 0);
    chk("illegal_ready", io.in_ready, 1);
`else
    offer(mkv(32'hFC000000, 0, 3'b000, 1, '0));
    chk("unknown_no_trap", io.illegal, 0);
    offer(mkv(32'h04611000, 0, 3'b000, 1, o(C_WR, 0, 1, 2, 3, 0)));
    chk("unknown_flow", io.out_valid, 1);
`endif

    // Reset while flushing with a held jump bundle.
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    offer(mkv({6'd14, 26'h10}, 0, 3'b000, 0, '0));
    chk("flush_setup", io.out_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_flush_valid", io.out_valid, 0);
    chk("rst_flush_ready", io.in_ready, 1);
    io.out_ready = 1'b1;
    v = mkv(enc(5, 12, 13, 16'h7000), 0, 3'b000, 1, o(C_WR, 4, 13, 14, 12, 0));
    offer(v);
    chk("rst_flush_issue", io.out_valid, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
